// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-sequence game: state codes shown on the
// debug display and the default response window.
package jogo_pkg;

   localparam int JOGO_TIMEOUT = 5000;
   localparam int JOGO_NT      = 13;

   localparam logic [3:0] ST_INICIAL     = 4'b0000;
   localparam logic [3:0] ST_PREPARACAO  = 4'b0001;
   localparam logic [3:0] ST_ESPERA      = 4'b0010;
   localparam logic [3:0] ST_REGISTRO    = 4'b0100;
   localparam logic [3:0] ST_COMPARACAO  = 4'b0101;
   localparam logic [3:0] ST_PROXIMO     = 4'b0110;
   localparam logic [3:0] ST_FIM_ACERTO  = 4'b1010;
   localparam logic [3:0] ST_FIM_ERRO    = 4'b1110;
   localparam logic [3:0] ST_FIM_TIMEOUT = 4'b1101;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with async and sync clears; fim flags the last count.
module contador_m #(
   parameter int M = 5000,
   parameter int N = 13
) (
   input  logic clock,
   input  logic zera_as,
   input  logic zera_s,
   input  logic conta,
   output logic fim
);

   localparam logic [N-1:0] ULTIMO = N'(M - 1);

   logic [N-1:0] q;

   // Wraps to zero after the last count so the counter never leaves 0..M-1.
   always_ff @(posedge clock or posedge zera_as) begin
      if (zera_as)
         q <= '0;
      else if (zera_s)
         q <= '0;
      else if (conta) begin
         if (q == ULTIMO)
            q <= '0;
         else
            q <= q + 1'b1;
      end
   end

   assign fim = (q == ULTIMO);

endmodule

// File: rtl/controle_jogada.sv
// Moore control unit for one round of the memory-sequence game: sequences
// the address counter, the play register and the per-play response window.
module controle_jogada
   import jogo_pkg::*;
#(
   parameter int TIMEOUT = JOGO_TIMEOUT,
   parameter int NT      = JOGO_NT
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fim_endereco,
   output logic       zera_endereco,
   output logic       conta_endereco,
   output logic       zera_registro,
   output logic       registra,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   logic [3:0] estado;
   logic [3:0] proximo_estado;
   logic       limpa_timeout;
   logic       fim_timeout;

   // Clearing on !reset_n keeps the window counter aligned with the FSM reset.
   contador_m #(
      .M(TIMEOUT),
      .N(NT)
   ) contador_timeout (
      .clock  (clock),
      .zera_as(1'b0),
      .zera_s (limpa_timeout | ~reset_n),
      .conta  (estado == ST_ESPERA),
      .fim    (fim_timeout)
   );

   always_ff @(posedge clock) begin
      if (!reset_n)
         estado <= ST_INICIAL;
      else
         estado <= proximo_estado;
   end

   always_comb begin
      proximo_estado = ST_INICIAL;
      case (estado)
         ST_INICIAL:     proximo_estado = iniciar ? ST_PREPARACAO : ST_INICIAL;
         ST_PREPARACAO:  proximo_estado = ST_ESPERA;
         // A play arriving on the very last window cycle still counts.
         ST_ESPERA: begin
            if (jogada)
               proximo_estado = ST_REGISTRO;
            else if (fim_timeout)
               proximo_estado = ST_FIM_TIMEOUT;
            else
               proximo_estado = ST_ESPERA;
         end
         ST_REGISTRO:    proximo_estado = ST_COMPARACAO;
         ST_COMPARACAO: begin
            if (!igual)
               proximo_estado = ST_FIM_ERRO;
            else if (fim_endereco)
               proximo_estado = ST_FIM_ACERTO;
            else
               proximo_estado = ST_PROXIMO;
         end
         ST_PROXIMO:     proximo_estado = ST_ESPERA;
         ST_FIM_ACERTO:  proximo_estado = iniciar ? ST_PREPARACAO : ST_FIM_ACERTO;
         ST_FIM_ERRO:    proximo_estado = iniciar ? ST_PREPARACAO : ST_FIM_ERRO;
         ST_FIM_TIMEOUT: proximo_estado = iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
         default:        proximo_estado = ST_INICIAL;
      endcase
   end

   assign limpa_timeout  = (estado == ST_PREPARACAO) || (estado == ST_PROXIMO);
   assign zera_endereco  = (estado == ST_PREPARACAO);
   assign zera_registro  = (estado == ST_PREPARACAO);
   assign conta_endereco = (estado == ST_PROXIMO);
   assign registra       = (estado == ST_REGISTRO);
   assign acertou        = (estado == ST_FIM_ACERTO);
   assign errou          = (estado == ST_FIM_ERRO);
   assign timeout        = (estado == ST_FIM_TIMEOUT);
   assign pronto         = acertou || errou || timeout;
   assign db_estado      = estado;

endmodule

// File: tb/tb_controle_jogada.sv
// Directed bench for controle_jogada with a short 8-cycle response window.
module tb_controle_jogada;

   localparam logic [3:0] S_INICIAL     = 4'b0000;
   localparam logic [3:0] S_PREPARACAO  = 4'b0001;
   localparam logic [3:0] S_ESPERA      = 4'b0010;
   localparam logic [3:0] S_REGISTRO    = 4'b0100;
   localparam logic [3:0] S_COMPARACAO  = 4'b0101;
   localparam logic [3:0] S_PROXIMO     = 4'b0110;
   localparam logic [3:0] S_FIM_ACERTO  = 4'b1010;
   localparam logic [3:0] S_FIM_ERRO    = 4'b1110;
   localparam logic [3:0] S_FIM_TIMEOUT = 4'b1101;

   logic       clock = 1'b0;
   logic       reset_n, iniciar, jogada, igual, fim_endereco;
   logic       zera_endereco, conta_endereco, zera_registro, registra;
   logic       pronto, acertou, errou, timeout;
   logic [3:0] db_estado;

   int checks = 0;
   int errors = 0;
   int conta_pulsos = 0;

   controle_jogada #(
      .TIMEOUT(8),
      .NT     (4)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .iniciar       (iniciar),
      .jogada        (jogada),
      .igual         (igual),
      .fim_endereco  (fim_endereco),
      .zera_endereco (zera_endereco),
      .conta_endereco(conta_endereco),
      .zera_registro (zera_registro),
      .registra      (registra),
      .pronto        (pronto),
      .acertou       (acertou),
      .errou         (errou),
      .timeout       (timeout),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (conta_endereco === 1'b1)
         conta_pulsos++;
   end

   // Output pattern {zera_end, conta_end, zera_reg, registra, pronto, acertou, errou, timeout}.
   function automatic logic [7:0] saidas_esperadas(input logic [3:0] st);
      case (st)
         S_PREPARACAO:  return 8'b1010_0000;
         S_PROXIMO:     return 8'b0100_0000;
         S_REGISTRO:    return 8'b0001_0000;
         S_FIM_ACERTO:  return 8'b0000_1100;
         S_FIM_ERRO:    return 8'b0000_1010;
         S_FIM_TIMEOUT: return 8'b0000_1001;
         default:       return 8'b0000_0000;
      endcase
   endfunction

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check_value(input string tag, input logic [15:0] observado,
                              input logic [15:0] esperado);
      checks++;
      assert (observado === esperado)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observado, esperado);
      end
   endtask

   task automatic check_output(input string tag, input logic [3:0] st);
      check_value({tag, "/estado"}, 16'(db_estado), 16'(st));
      check_value({tag, "/saidas"},
                  16'({zera_endereco, conta_endereco, zera_registro, registra,
                       pronto, acertou, errou, timeout}),
                  16'(saidas_esperadas(st)));
   endtask

   task automatic apply_stimulus(input logic ig, input logic fe);
      jogada = 1'b1;
      tick();
      check_output("registro", S_REGISTRO);
      jogada       = 1'b0;
      igual        = ig;
      fim_endereco = fe;
      tick();
      check_output("comparacao", S_COMPARACAO);
      tick();
   endtask

   task automatic start_round(input string tag);
      iniciar = 1'b1;
      tick();
      check_output({tag, "/prep"}, S_PREPARACAO);
      iniciar = 1'b0;
      tick();
      check_output({tag, "/espera"}, S_ESPERA);
   endtask

   initial begin
      reset_n = 1'b0; iniciar = 1'b0; jogada = 1'b0;
      igual = 1'b0; fim_endereco = 1'b0;
      tick(2);
      check_output("reset", S_INICIAL);
      reset_n = 1'b1;
      tick();
      check_output("idle", S_INICIAL);

      $display("[TB] full hit, 4 words");
      start_round("hit");
      conta_pulsos = 0;
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(1'b1, 1'b0);
         check_output("hit/proximo", S_PROXIMO);
         tick();
         check_output("hit/volta", S_ESPERA);
      end
      apply_stimulus(1'b1, 1'b1);
      check_output("hit/fim", S_FIM_ACERTO);
      tick(2);
      check_output("hit/mantem", S_FIM_ACERTO);
      check_value("hit/pulsos", 16'(conta_pulsos), 16'd3);

      $display("[TB] miss on second play");
      start_round("miss");
      conta_pulsos = 0;
      fim_endereco = 1'b0;
      apply_stimulus(1'b1, 1'b0);
      check_output("miss/proximo", S_PROXIMO);
      tick();
      apply_stimulus(1'b0, 1'b0);
      check_output("miss/fim", S_FIM_ERRO);
      check_value("miss/pulsos", 16'(conta_pulsos), 16'd1);

      $display("[TB] timeout with iniciar ignored in espera");
      start_round("restart_erro");
      for (int c = 1; c < 8; c++) begin
         iniciar = (c == 3);
         tick();
         iniciar = 1'b0;
         check_output($sformatf("to/espera%0d", c + 1), S_ESPERA);
      end
      tick();
      check_output("to/fim", S_FIM_TIMEOUT);

      $display("[TB] play on the last window cycle");
      start_round("last");
      tick(7);
      check_output("last/c8", S_ESPERA);
      jogada = 1'b1;
      tick();
      check_output("last/registro", S_REGISTRO);
      jogada = 1'b0; igual = 1'b1; fim_endereco = 1'b0;
      tick();
      check_output("last/comparacao", S_COMPARACAO);
      jogada = 1'b1;
      tick();
      check_output("last/proximo", S_PROXIMO);
      jogada = 1'b0;
      tick();
      check_output("last/espera", S_ESPERA);

      $display("[TB] fresh window after each play");
      tick(6);
      apply_stimulus(1'b1, 1'b0);
      check_output("win/proximo1", S_PROXIMO);
      tick();
      tick(6);
      check_output("win/c7", S_ESPERA);
      apply_stimulus(1'b1, 1'b0);
      check_output("win/proximo2", S_PROXIMO);

      $display("[TB] reset during comparacao");
      tick();
      jogada = 1'b1;
      tick();
      jogada = 1'b0; igual = 1'b1; fim_endereco = 1'b1;
      tick();
      check_output("rst/comparacao", S_COMPARACAO);
      reset_n = 1'b0;
      tick();
      check_output("rst/inicial", S_INICIAL);
      reset_n = 1'b1;
      tick();
      check_output("rst/apos", S_INICIAL);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
